// File: rtl/round_sgf_stage.sv
// round_sgf_stage: applies the rounding increment to a truncated significand and renormalises on carry.
module round_sgf_stage #(
   parameter int W_Exp = 8,
   parameter int W_Sgf = 23
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic                     sgn_i,
   input  logic [W_Exp-1:0]         exp_i,
   input  logic [W_Sgf:0]           sgf_i,
   input  logic                     ctrl_i,
   output logic [W_Exp+W_Sgf:0]     result_o,
   output logic                     ready_o,
   output logic                     busy_o,
   output logic                     overflow_o
);
   typedef enum logic [1:0] {IDLE, ROUND, NORM, DONE} state_t;
   state_t state, state_n;
   logic               sgn_r, ctrl_r;
   logic [W_Exp-1:0]   exp_r, exp_inc, exp_n;
   logic [W_Sgf:0]     sgf_r;
   logic [W_Sgf+1:0]   sum_r;
   logic [W_Sgf-1:0]   frac_n;
   logic               carry, special, ovf_n;
   always_comb begin
      state_n = (state == IDLE)  ? (start_i ? ROUND : IDLE) :
                (state == ROUND) ? NORM :
                (state == NORM)  ? DONE : IDLE;
      exp_inc = exp_r + 1'b1;
      carry   = sum_r[W_Sgf+1];
      special = &exp_r;
      ovf_n   = !special && carry && (&exp_inc);
      exp_n   = (!special && carry) ? exp_inc : exp_r;
      frac_n  = ovf_n   ? '0 :
                special ? sgf_r[W_Sgf-1:0] :
                carry   ? sum_r[W_Sgf:1] : sum_r[W_Sgf-1:0];
   end
   assign ready_o = (state == DONE);
   assign busy_o  = (state != IDLE);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sgn_r      <= 1'b0;
         ctrl_r     <= 1'b0;
         exp_r      <= '0;
         sgf_r      <= '0;
         sum_r      <= '0;
         result_o   <= '0;
         overflow_o <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && start_i) begin
            sgn_r  <= sgn_i;
            exp_r  <= exp_i;
            sgf_r  <= sgf_i;
            ctrl_r <= ctrl_i;
         end
         if (state == ROUND)
            sum_r <= {1'b0, sgf_r} + {{(W_Sgf+1){1'b0}}, ctrl_r};
         if (state == NORM) begin
            result_o   <= {sgn_r, exp_n, frac_n};
            overflow_o <= ovf_n;
         end
      end
   end
endmodule

// File: tb/tb_round_sgf_stage.sv
// tb_round_sgf_stage: scoreboard bench for the rounding stage (default 8/23 format).
module tb_round_sgf_stage;
   logic        clk = 1'b0;
   logic        rst_n, start_i, sgn_i, ctrl_i;
   logic [7:0]  exp_i;
   logic [23:0] sgf_i;
   logic [31:0] result_o;
   logic        ready_o, busy_o, overflow_o;
   int          checks = 0, errors = 0;
   logic [32:0] q[$];
   logic [32:0] e_v;

   round_sgf_stage dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .sgn_i(sgn_i), .exp_i(exp_i),
      .sgf_i(sgf_i), .ctrl_i(ctrl_i), .result_o(result_o), .ready_o(ready_o),
      .busy_o(busy_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [32:0] model(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c);
      int unsigned v;
      int          ee;
      if (e == 8'hFF) return {1'b0, s, e, m[22:0]};
      v  = m + c;
      ee = e;
      if (v >= 32'h0100_0000) begin
         v  = v / 2;
         ee = ee + 1;
      end
      if (ee == 255) return {1'b1, s, 8'hFF, 23'd0};
      return {1'b0, s, ee[7:0], v[22:0]};
   endfunction

   // Scoreboard side: every ready pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (ready_o) begin
         if (q.size() == 0) chk("extra_ready", {63'd0, ready_o}, 64'd0);
         else begin
            e_v = q.pop_front();
            chk("result", {32'd0, result_o}, {32'd0, e_v[31:0]});
            chk("overflow", {63'd0, overflow_o}, {63'd0, e_v[32]});
         end
      end
   end

   // Called at a negedge; returns at a negedge with the DUT back in IDLE.
   task automatic op(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c,
                     input logic [32:0] exp_v, input bit poke);
      int n;
      sgn_i = s; exp_i = e; sgf_i = m; ctrl_i = c; start_i = 1'b1;
      q.push_back(exp_v);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (poke) begin
            sgn_i = ~s; exp_i = e ^ 8'h5A; sgf_i = ~m; ctrl_i = ~c;
         end else start_i = 1'b0;
      end while (!ready_o && n < 8);
      start_i = 1'b0;
      chk("latency", 64'(n), 64'd3);
      chk("busy_done", {63'd0, busy_o}, 64'd1);
      @(negedge clk);
   endtask

   initial begin
      logic       s, c;
      logic [7:0] e;
      logic [23:0] m;
      int         sel;
      rst_n = 1'b0; start_i = 1'b1; sgn_i = 1'b1; ctrl_i = 1'b1; exp_i = 8'h12; sgf_i = 24'hABCDEF;
      repeat (3) @(negedge clk);
      chk("rst_result", {32'd0, result_o}, 64'd0);
      chk("rst_ready", {63'd0, ready_o}, 64'd0);
      chk("rst_busy", {63'd0, busy_o}, 64'd0);
      chk("rst_ovf", {63'd0, overflow_o}, 64'd0);
      rst_n = 1'b1;
      op(1'b0, 8'h7F, 24'h800000, 1'b1, {1'b0, 32'h3F800001}, 1'b0);
      op(1'b0, 8'h7F, 24'hFFFFFF, 1'b1, {1'b0, 32'h40000000}, 1'b0);
      op(1'b1, 8'hFE, 24'hFFFFFF, 1'b1, {1'b1, 32'hFF800000}, 1'b1);
      repeat (3) @(negedge clk);
      chk("hold", {31'd0, overflow_o, result_o}, {31'd0, 1'b1, 32'hFF800000});
      op(1'b1, 8'h7F, 24'hC00000, 1'b0, {1'b0, 32'hBFC00000}, 1'b0);
      op(1'b0, 8'hFF, 24'hC00001, 1'b1, {1'b0, 32'h7FC00001}, 1'b1);
      // Abort in NORM: no ready pulse, everything cleared.
      sgn_i = 1'b1; exp_i = 8'h80; sgf_i = 24'hFFFFFF; ctrl_i = 1'b1; start_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      @(negedge clk);
      chk("abort_result", {32'd0, result_o}, 64'd0);
      chk("abort_ready", {63'd0, ready_o}, 64'd0);
      chk("abort_busy", {63'd0, busy_o}, 64'd0);
      chk("abort_ovf", {63'd0, overflow_o}, 64'd0);
      @(negedge clk);
      chk("rst_start_ignored", {63'd0, busy_o}, 64'd0);
      rst_n = 1'b1;
      op(1'b1, 8'h80, 24'h800001, 1'b1, {1'b0, 32'hC0000002}, 1'b0);
      for (int i = 0; i < 24; i++) begin
         s   = 1'($urandom_range(0, 1));
         c   = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 3);
         e   = (sel == 0) ? 8'hFE : (sel == 1) ? 8'hFF : (sel == 2) ? 8'h00 : 8'($urandom_range(1, 253));
         m   = $urandom_range(0, 1) ? 24'hFFFFFF : {1'b1, 23'($urandom)};
         op(s, e, m, c, model(s, e, m, c), (i % 3) == 0);
      end
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/round_sgf_stage.md
ROUND_SGF_STAGE -- requirements
Module: round_sgf_stage

Interface
REQ-001 SHALL have parameter W_Exp, default 8, exponent width.
REQ-002 SHALL have parameter W_Sgf, default 23, stored fraction width (hidden bit excluded).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  request strobe; sampled only in IDLE.
REQ-006 SHALL have port sgn_i  input  1  sign of the operand.
REQ-007 SHALL have port exp_i  input  W_Exp  biased exponent.
REQ-008 SHALL have port sgf_i  input  W_Sgf+1  significand with hidden bit at MSB, already truncated.
REQ-009 SHALL have port ctrl_i  input  1  round control from the rounding-decoder stage; 1 = increment significand, 0 = pass truncated.
REQ-010 SHALL have port result_o  output  1+W_Exp+W_Sgf  packed {sign, exponent, fraction}.
REQ-011 SHALL have port ready_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-013 SHALL have port overflow_o  output  1  rounding carried exponent to all-ones.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, ROUND, NORM, DONE.
REQ-015 IDLE: start_i=1 at an edge SHALL capture sgn_i, exp_i, sgf_i, ctrl_i into internal registers and go to ROUND; start_i=0 stays IDLE.
REQ-016 ROUND: SHALL register sum = zero-extended captured sgf + ctrl (W_Sgf+2 bits), then go to NORM.
REQ-017 NORM: if sum MSB (carry) = 1, SHALL shift sum right by one and register exp+1; else keep sum low W_Sgf+1 bits and exp unchanged; then go to DONE.
REQ-018 NORM: if incremented exponent equals all-ones, SHALL force fraction to zero (infinity) and set overflow_o.
REQ-019 NORM: if captured exponent is already all-ones (Inf/NaN), SHALL pass captured sgf and exp unchanged, ignoring ctrl, overflow_o stays 0.
REQ-020 result_o SHALL be updated only at the NORM->DONE edge: {captured sign, final exp, final sgf minus hidden bit}.
REQ-021 DONE: ready_o SHALL be 1 for exactly this one cycle; next state IDLE unconditionally.
REQ-022 Latency: start_i sampled at edge k SHALL give ready_o=1 in the cycle after edge k+2; throughput one operation per 4 cycles.
REQ-023 start_i while busy_o=1 SHALL be ignored, without queuing or modifying captured operands.
REQ-024 result_o and overflow_o SHALL hold their values until the next NORM->DONE edge.
REQ-025 Sign SHALL never be altered by rounding or overflow.

Reset
REQ-026 rst_n=0 at an edge SHALL force state IDLE, result_o=0, ready_o=0, busy_o=0, overflow_o=0, all internal registers 0, regardless of state.
REQ-027 rst_n=0 during ROUND/NORM/DONE SHALL abort the operation with no ready_o pulse; start_i is ignored while rst_n=0.
REQ-028 First start_i SHALL be accepted at the first edge with rst_n=1.

Verification
REQ-029 sgn=0, exp=8'h7F, sgf=24'h800000, ctrl=1 -> result_o=32'h3F800001, overflow_o=0, ready_o 3 cycles after start.
REQ-030 sgn=0, exp=8'h7F, sgf=24'hFFFFFF, ctrl=1 -> carry renormalise, result_o=32'h40000000.
REQ-031 sgn=1, exp=8'hFE, sgf=24'hFFFFFF, ctrl=1 -> result_o=32'hFF800000, overflow_o=1.
REQ-032 sgn=1, exp=8'h7F, sgf=24'hC00000, ctrl=0 -> result_o=32'hBFC00000; exp=8'hFF, sgf=24'hC00001, ctrl=1 -> result_o=32'h7FC00001 (sgn=0).
REQ-033 start during busy, then rst_n=0 in NORM -> no ready_o, all outputs 0; next start after reset completes normally.
